tile_flusher: RTL and testbench
===============================

Name: tile_flusher

Overview:
- Consumer end of the shader tile buffers: reads a completed 8x8 nanoTile of RGB565 pixels and writes it into the SRAM framebuffer at its screen position.
- Sits between the pixel shader's double-buffered tile arrays and the SRAM controller pins. While the shader rasterizes one buffer, this block drains the other one.
- Uses a start/done level handshake with the tile scheduler, matching the rasterizer's handshake.

Parameters:
nanoTileDim, 8, tile edge in pixels (tile is nanoTileDim x nanoTileDim)
screenWidth, 640, framebuffer width in pixels; also the row stride in words
screenHeight, 480, framebuffer height in pixels
addrWidth, 20, SRAM word address width

Ports:
BOARD_CLK  in  1  sole clock
RESET_N  in  1  asynchronous active-low reset
startFlush  in  1  level request from the scheduler
flushTileID  in  1  0 selects nanoTile0, 1 selects nanoTile1
tileOffsetX  in  10  screen x of tile pixel [0][0]
tileOffsetY  in  10  screen y of tile pixel [0][0]
nanoTile0  in  16 x [nanoTileDim][nanoTileDim]  tile buffer 0, indexed [x][y]
nanoTile1  in  16 x [nanoTileDim][nanoTileDim]  tile buffer 1, indexed [x][y]
memBusy  in  1  SRAM arbitration stall (VGA scan-out has priority)
SRAM_ADDR  out  addrWidth  word address
SRAM_DQ_OUT  out  16  write data; the top level builds the tristate
SRAM_DQ_OE  out  1  data drive enable
SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM strobes
doneFlushing  out  1  high while in DONE

Behaviour:
- Clock and reset: one clock, BOARD_CLK. Reset RESET_N is asynchronous, active-low.
- Reset values: state IDLE, col=row=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, SRAM_DQ_OE=0, SRAM_WE_N=1, SRAM_CE_N=1, SRAM_OE_N=1, SRAM_UB_N=1, SRAM_LB_N=1, doneFlushing=0.
- Reset asserted mid-flush aborts the flush immediately. No partial write strobe may remain low.
- All outputs are registered. SRAM_OE_N is always 1 outside reset (write-only block).
- IDLE: if startFlush=1 go to LATCH, otherwise stay.
- LATCH (1 cycle):
  - capture flushTileID, tileOffsetX and tileOffsetY; clear col and row.
  - Later changes to these inputs are ignored until the next LATCH.
  - Go to SETUP.
- SETUP:
  - Screen position: px = offX + col, py = offY + row, computed at 11 bits.
  - If px >= screenWidth or py >= screenHeight, the pixel is clipped: one cycle, no strobe, then advance.
  - Otherwise drive SRAM_ADDR = (py*screenWidth + px) truncated to addrWidth.
  - Drive SRAM_DQ_OUT = the selected tile's [col][row]; set SRAM_DQ_OE=1, SRAM_CE_N=0, SRAM_UB_N=0, SRAM_LB_N=0, SRAM_WE_N=1.
  - If memBusy=1, stay in SETUP with WE_N held at 1. Otherwise go to STROBE.
- STROBE (1 cycle):
  - SRAM_WE_N=0; address and data are unchanged from SETUP. memBusy is ignored.
  - Then advance.
- Advance order is row-major: col++, and on reaching nanoTileDim set col=0 and row++.
  - After pixel (nanoTileDim-1, nanoTileDim-1) go to DONE.
  - Otherwise go to SETUP.
- DONE:
  - doneFlushing=1; CE_N, UB_N and LB_N return to 1; DQ_OE=0.
  - Stay while startFlush=1. Go to IDLE on the first cycle startFlush=0.
- Latency with no stall and no clipping:
  - startFlush sampled in IDLE at cycle 0 → LATCH at 1 → pixel i has SETUP at 2+2i and STROBE at 3+2i.
  - doneFlushing rises at cycle 2+2·nanoTileDim² (130 for dim 8).
- startFlush dropped mid-flush: ignored. The flush completes, then DONE lasts exactly 1 cycle.
- startFlush held across DONE→IDLE is not possible: leaving DONE requires startFlush=0, so each request flushes exactly once.
- Pixel data is sampled in SETUP. The scheduler must not let the shader write the selected buffer until doneFlushing=1.

Test Plan:
- Basic flush: nanoTile0[x][y]=16'h0100·y+x, ID=0, offset (16,8), memBusy=0, start held → 64 WE_N pulses; pixel (3,2) is written to addr 10·640+19=6419 with data 16'h0203; doneFlushing high at cycle 130.
- Buffer select: nanoTile1 all 16'hF81F, nanoTile0 all 0, ID=1, offset (0,0) → every write is F81F; the last write goes to addr 7·640+7=4487.
- Clipping: offset (636,476) → only the 16 pixels with px<640 and py<480 are strobed; clipped pixels take 1 cycle each; doneFlushing at cycle 2+16·2+48=82.
- Stall: memBusy=1 for 5 cycles during pixel 0's SETUP → WE_N stays 1 and address/data stay stable; STROBE follows the first memBusy=0 cycle; done is 5 cycles later than baseline.
- Handshake: start held 10 cycles after done → doneFlushing high 10 cycles, then one IDLE cycle; change tileOffsetX mid-flush → addresses unaffected.
- Reset mid-flush: RESET_N low at pixel 20's STROBE → same cycle WE_N=1, CE_N=1, doneFlushing=0; after release with start=1 the flush restarts at pixel 0.

Source files
------------

// File: rtl/tile_flusher.sv
// tile_flusher: drains a completed 8x8 RGB565 nanoTile into the SRAM framebuffer at its screen position.
module tile_flusher #(
  parameter int nanoTileDim  = 8,
  parameter int screenWidth  = 640,
  parameter int screenHeight = 480,
  parameter int addrWidth    = 20
) (
  input  logic                                          BOARD_CLK,
  input  logic                                          RESET_N,
  input  logic                                          startFlush,
  input  logic                                          flushTileID,
  input  logic [9:0]                                    tileOffsetX,
  input  logic [9:0]                                    tileOffsetY,
  input  logic [nanoTileDim-1:0][nanoTileDim-1:0][15:0] nanoTile0,
  input  logic [nanoTileDim-1:0][nanoTileDim-1:0][15:0] nanoTile1,
  input  logic                                          memBusy,
  output logic [addrWidth-1:0]                          SRAM_ADDR,
  output logic [15:0]                                   SRAM_DQ_OUT,
  output logic                                          SRAM_DQ_OE,
  output logic                                          SRAM_WE_N,
  output logic                                          SRAM_CE_N,
  output logic                                          SRAM_OE_N,
  output logic                                          SRAM_UB_N,
  output logic                                          SRAM_LB_N,
  output logic                                          doneFlushing
);
  localparam int CW = $clog2(nanoTileDim);
  typedef enum logic [2:0] {IDLE, LATCH, SETUP, STROBE, DONE} state_t;
  state_t state, nxt_state;
  logic [CW-1:0] col, row, nxt_col, nxt_row;
  logic sel, sel_n;
  logic [9:0] off_x, off_y, off_x_n, off_y_n;
  logic [10:0] cpx, cpy, npx, npy;
  logic cur_clip, nxt_clip, last, adv, wr, stb;
  logic [addrWidth-1:0] addr_n;
  logic [15:0] dq_n;
  // Outputs are registered from the next state, so each state's strobes are visible during that state.
  always_comb begin
    sel_n = state == LATCH ? flushTileID : sel;
    off_x_n = state == LATCH ? tileOffsetX : off_x;
    off_y_n = state == LATCH ? tileOffsetY : off_y;
    cpx = 11'(off_x) + 11'(col);
    cpy = 11'(off_y) + 11'(row);
    cur_clip = cpx >= 11'(screenWidth) || cpy >= 11'(screenHeight);
    last = col == CW'(nanoTileDim - 1) && row == CW'(nanoTileDim - 1);
    adv = state == STROBE || (state == SETUP && cur_clip);
    nxt_state = state;
    nxt_col = col;
    nxt_row = row;
    case (state)
      IDLE: nxt_state = startFlush ? LATCH : IDLE;
      LATCH: begin
        nxt_state = SETUP;
        nxt_col = '0;
        nxt_row = '0;
      end
      SETUP: nxt_state = memBusy ? SETUP : STROBE;
      DONE: nxt_state = startFlush ? DONE : IDLE;
      default: ;
    endcase
    if (adv) begin
      nxt_state = last ? DONE : SETUP;
      nxt_col = col == CW'(nanoTileDim - 1) ? '0 : col + 1'b1;
      nxt_row = col == CW'(nanoTileDim - 1) ? row + 1'b1 : row;
    end
    npx = 11'(off_x_n) + 11'(nxt_col);
    npy = 11'(off_y_n) + 11'(nxt_row);
    nxt_clip = npx >= 11'(screenWidth) || npy >= 11'(screenHeight);
    wr = nxt_state == SETUP && !nxt_clip;
    stb = nxt_state == STROBE;
    addr_n = wr ? addrWidth'(32'(npy) * screenWidth + 32'(npx)) : SRAM_ADDR;
    dq_n = wr ? (sel_n ? nanoTile1[nxt_col][nxt_row] : nanoTile0[nxt_col][nxt_row]) : SRAM_DQ_OUT;
  end
  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      sel <= 1'b0;
      off_x <= '0;
      off_y <= '0;
      SRAM_ADDR <= '0;
      SRAM_DQ_OUT <= '0;
      SRAM_DQ_OE <= 1'b0;
      SRAM_WE_N <= 1'b1;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      doneFlushing <= 1'b0;
    end else begin
      state <= nxt_state;
      col <= nxt_col;
      row <= nxt_row;
      sel <= sel_n;
      off_x <= off_x_n;
      off_y <= off_y_n;
      SRAM_ADDR <= addr_n;
      SRAM_DQ_OUT <= dq_n;
      SRAM_DQ_OE <= wr || stb;
      SRAM_WE_N <= !stb;
      SRAM_CE_N <= !(wr || stb);
      SRAM_OE_N <= 1'b1;
      SRAM_UB_N <= !(wr || stb);
      SRAM_LB_N <= !(wr || stb);
      doneFlushing <= nxt_state == DONE;
    end
  end
endmodule

// File: tb/tb_tile_flusher.sv
// tb_tile_flusher: randomized and directed flushes checked against a per-pixel framebuffer write model.
module tb_tile_flusher;
  logic BOARD_CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic startFlush = 1'b0;
  logic flushTileID = 1'b0;
  logic [9:0] tileOffsetX = '0;
  logic [9:0] tileOffsetY = '0;
  logic [7:0][7:0][15:0] nanoTile0, nanoTile1;
  logic memBusy = 1'b0;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_OUT;
  logic SRAM_DQ_OE, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, doneFlushing;

  tile_flusher dut (
    .BOARD_CLK(BOARD_CLK), .RESET_N(RESET_N), .startFlush(startFlush), .flushTileID(flushTileID),
    .tileOffsetX(tileOffsetX), .tileOffsetY(tileOffsetY), .nanoTile0(nanoTile0), .nanoTile1(nanoTile1),
    .memBusy(memBusy), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .doneFlushing(doneFlushing)
  );

  always #5 BOARD_CLK = ~BOARD_CLK;

  int compares = 0;
  int fails = 0;
  int cyc = 0;
  int e0, rel;
  logic [19:0] got_addr[$], exp_addr[$];
  logic [15:0] got_data[$], exp_data[$];
  logic [4:0] got_ctl[$];

  always @(posedge BOARD_CLK) cyc <= cyc + 1;

  // Every write strobe seen on the pins, with {CE_N,UB_N,LB_N,DQ_OE,OE_N} at that moment.
  always @(negedge BOARD_CLK)
    if (RESET_N && !SRAM_WE_N) begin
      got_addr.push_back(SRAM_ADDR);
      got_data.push_back(SRAM_DQ_OUT);
      got_ctl.push_back({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_OE, SRAM_OE_N});
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int build_model(input logic s, input int ox, input int oy);
    int nclip = 0;
    exp_addr = {};
    exp_data = {};
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (ox + x < 640 && oy + y < 480) begin
          exp_addr.push_back(20'((oy + y) * 640 + ox + x));
          exp_data.push_back(s ? nanoTile1[x][y] : nanoTile0[x][y]);
        end else nclip++;
    return 2 + 2 * exp_addr.size() + nclip;
  endfunction

  task automatic flush(input string tag, input logic s, input logic [9:0] ox, input logic [9:0] oy,
                       input int stall, input int drop_at, input int chg_at, input int hold_after);
    int exp_done;
    bit seen = 0;
    got_addr = {};
    got_data = {};
    got_ctl = {};
    exp_done = build_model(s, int'(ox), int'(oy)) + stall;
    flushTileID = s;
    tileOffsetX = ox;
    tileOffsetY = oy;
    memBusy = stall > 0;
    @(negedge BOARD_CLK);
    startFlush = 1'b1;
    @(posedge BOARD_CLK);
    #1 e0 = cyc;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge BOARD_CLK);
      rel = cyc - e0 + 1;
      if (doneFlushing) seen = 1;
      else begin
        if (stall > 0 && rel >= 2 && rel <= 2 + stall) begin
          chk({tag, "_stall_we"}, 32'(SRAM_WE_N), 32'd1);
          chk({tag, "_stall_addr"}, 32'(SRAM_ADDR), 32'(exp_addr[0]));
          chk({tag, "_stall_data"}, 32'(SRAM_DQ_OUT), 32'(exp_data[0]));
        end
        if (rel == 2 + stall) memBusy = 1'b0;
        if (rel == drop_at) startFlush = 1'b0;
        if (rel == chg_at) begin
          tileOffsetX = 10'($urandom);
          tileOffsetY = 10'($urandom);
          flushTileID = ~s;
        end
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_done_cycle"}, 32'(rel), 32'(exp_done));
    for (int k = 0; k < hold_after; k++) begin
      @(negedge BOARD_CLK);
      chk({tag, "_done_hold"}, 32'(doneFlushing), 32'd1);
    end
    startFlush = 1'b0;
    @(negedge BOARD_CLK);
    chk({tag, "_done_drop"}, 32'(doneFlushing), 32'd0);
    chk({tag, "_idle_ce"}, 32'({SRAM_CE_N, SRAM_WE_N, SRAM_DQ_OE}), 32'b110);
    chk({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      chk({tag, "_addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
      chk({tag, "_data"}, 32'(got_data[i]), 32'(exp_data[i]));
      chk({tag, "_ctl"}, 32'(got_ctl[i]), 32'b00011);
    end
  endtask

  initial begin
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        nanoTile0[x][y] = 16'(16'h0100 * y + x);
        nanoTile1[x][y] = 16'($urandom);
      end
    #23;
    chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
    chk("rst_dq", 32'(SRAM_DQ_OUT), 32'd0);
    chk("rst_strobes", 32'({SRAM_DQ_OE, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}), 32'b011111);
    chk("rst_done", 32'(doneFlushing), 32'd0);
    @(negedge BOARD_CLK);
    RESET_N = 1'b1;
    @(negedge BOARD_CLK);
    chk("idle_oe_n", 32'(SRAM_OE_N), 32'd1);

    flush("basic", 1'b0, 10'd16, 10'd8, 0, 0, 0, 0);
    chk("basic_px32_addr", 32'(got_addr[19]), 32'd6419);
    chk("basic_px32_data", 32'(got_data[19]), 32'h0203);

    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        nanoTile0[x][y] = 16'h0000;
        nanoTile1[x][y] = 16'hF81F;
      end
    flush("bufsel", 1'b1, 10'd0, 10'd0, 0, 0, 0, 0);
    chk("bufsel_last_addr", 32'(got_addr[got_addr.size() - 1]), 32'd4487);

    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        nanoTile0[x][y] = 16'($urandom);
        nanoTile1[x][y] = 16'($urandom);
      end
    flush("clip", 1'b0, 10'd636, 10'd476, 0, 0, 0, 0);
    chk("clip_count", 32'(got_addr.size()), 32'd16);
    flush("stall", 1'b1, 10'd16, 10'd8, 5, 0, 0, 0);
    flush("hold", 1'b0, 10'd200, 10'd100, 0, 0, 0, 10);
    flush("midchg", 1'b1, 10'd320, 10'd240, 0, 5, 10, 0);
    flush("allclip", 1'b0, 10'd700, 10'd10, 0, 0, 0, 0);

    for (int n = 0; n < 6; n++) begin
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++) begin
          nanoTile0[x][y] = 16'($urandom);
          nanoTile1[x][y] = 16'($urandom);
        end
      flush("rand", 1'($urandom), 10'($urandom_range(0, 645)), 10'($urandom_range(0, 485)),
            int'($urandom_range(0, 3)), 0, 0, int'($urandom_range(0, 3)));
    end

    flushTileID = 1'b0;
    tileOffsetX = 10'd100;
    tileOffsetY = 10'd50;
    @(negedge BOARD_CLK);
    startFlush = 1'b1;
    @(posedge BOARD_CLK);
    #1 e0 = cyc;
    rel = 1;
    for (int k = 0; k < 200 && rel != 43; k++) begin
      @(negedge BOARD_CLK);
      rel = cyc - e0 + 1;
    end
    chk("rst_mid_reached", 32'(rel), 32'd43);
    chk("rst_mid_pre_we", 32'(SRAM_WE_N), 32'd0);
    #1 RESET_N = 1'b0;
    startFlush = 1'b0;
    #1;
    chk("rst_mid_we", 32'(SRAM_WE_N), 32'd1);
    chk("rst_mid_ce", 32'(SRAM_CE_N), 32'd1);
    chk("rst_mid_done", 32'(doneFlushing), 32'd0);
    @(negedge BOARD_CLK);
    RESET_N = 1'b1;
    flush("after_rst", 1'b0, 10'd100, 10'd50, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
